// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control FSM.
// Sequences each instruction over 3-5 states around one shared ALU and one
// unified memory port. Memory accesses wait on mem_ready_i. An optional
// watchdog (WAIT_LIMIT > 0) aborts an access stuck low for WAIT_LIMIT cycles.
// Optional feature macro: MC_BNE_EN adds the BNE state and the branch_ne_o port.
//
// state    | meaning
// ---------+------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4 when memory ready
// DECODE   | read registers, precompute branch target, dispatch
// MEMADR   | compute lw/sw effective address
// MEMRD    | load data read, waits on mem_ready
// MEMWB    | write loaded data to rt
// MEMWR    | store data write, waits on mem_ready
// RTYPE_EX | R-type ALU operation
// ALU_WB   | write ALU result to rd
// BRANCH   | beq compare, PC <= target if equal
// ADDI_EX  | addi ALU operation
// ADDI_WB  | write ALU result to rt
// JUMP     | PC <= jump target
// BNE      | bne compare, PC <= target if not equal (MC_BNE_EN only)
module mips_multicycle_control #(
    parameter int OPCODE_W   = 6,
    parameter int WAIT_LIMIT = 0,
    parameter int STATE_W    = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                mem_ready_i,
    output logic                mem_req_o,
    output logic                iord_o,
    output logic                ir_write_o,
    output logic                pc_write_o,
    output logic                branch_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [1:0]          alu_op_o,
    output logic [1:0]          pc_src_o,
    output logic                reg_dst_o,
    output logic                mem2reg_o,
    output logic                we3_o,
    output logic                we_o,
    output logic                illegal_op_o,
    output logic                bus_err_o,
`ifdef MC_BNE_EN
    output logic                branch_ne_o,
`endif
    output logic [STATE_W-1:0]  state_o
);

    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMRD    = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWR    = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_RTYPE_EX = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_ALU_WB   = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_ADDI_EX  = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_ADDI_WB  = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_JUMP     = STATE_W'(11);
`ifdef MC_BNE_EN
    localparam logic [STATE_W-1:0] S_BNE      = STATE_W'(12);
    localparam logic [OPCODE_W-1:0] OP_BNE    = OPCODE_W'(6'b000101);
`endif

    localparam logic [OPCODE_W-1:0] OP_LW     = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW     = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_RTYPE  = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_BEQ    = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ADDI   = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_J      = OPCODE_W'(6'b000010);

    logic [STATE_W-1:0] state_q, state_d;
    logic               is_sw_q, is_sw_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q;
    logic               mem_state;
    logic               timeout;

    // States that wait on the memory handshake and are covered by the watchdog.
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    generate
        if (WAIT_LIMIT > 0) begin : g_wdog
            localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
            logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

            // Timeout fires on the WAIT_LIMIT-th consecutive low cycle; a ready
            // on that same cycle completes the access normally.
            assign timeout = mem_state && !mem_ready_i &&
                             (wait_cnt_q == CNT_W'(WAIT_LIMIT - 1));

            // Count low cycles in a waiting state; restart on any state entry.
            always_comb begin
                wait_cnt_d = '0;
                if (mem_state && (state_d == state_q) && !timeout && !mem_ready_i)
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end

            // Watchdog counter register.
            always_ff @(posedge clk_i) begin
                if (reset_i) wait_cnt_q <= '0;
                else         wait_cnt_q <= wait_cnt_d;
            end
        end else begin : g_no_wdog
            assign timeout = 1'b0;
        end
    endgenerate

    // Next-state logic; opcode is only looked at in DECODE and the lw/sw
    // choice is latched there so later opcode changes cannot redirect it.
    always_comb begin
        state_d   = state_q;
        is_sw_d   = is_sw_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                is_sw_d = (opcode_i == OP_SW);
                case (opcode_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = S_BNE;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (mem_ready_i) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (mem_ready_i) state_d = S_FETCH;
            S_RTYPE_EX: state_d = S_ALU_WB;
            S_ALU_WB:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
`ifdef MC_BNE_EN
            S_BNE:      state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
        if (timeout) state_d = S_FETCH;
    end

    // State and pulse registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_FETCH;
            is_sw_q   <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_sw_q   <= is_sw_d;
            illegal_q <= illegal_d;
            bus_err_q <= timeout;
        end
    end

    // Moore output decode, all forced low while reset is high.
    always_comb begin
        mem_req_o    = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        branch_o     = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        pc_src_o     = 2'b00;
        reg_dst_o    = 1'b0;
        mem2reg_o    = 1'b0;
        we3_o        = 1'b0;
        we_o         = 1'b0;
        illegal_op_o = 1'b0;
        bus_err_o    = 1'b0;
`ifdef MC_BNE_EN
        branch_ne_o  = 1'b0;
`endif
        if (!reset_i) begin
            illegal_op_o = illegal_q;
            bus_err_o    = bus_err_q;
            case (state_q)
                S_FETCH: begin
                    mem_req_o   = 1'b1;
                    alu_src_b_o = 2'b01;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                S_DECODE:   alu_src_b_o = 2'b11;
                S_MEMADR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                end
                S_MEMRD: begin
                    mem_req_o = 1'b1;
                    iord_o    = 1'b1;
                end
                S_MEMWB: begin
                    mem2reg_o = 1'b1;
                    we3_o     = 1'b1;
                end
                S_MEMWR: begin
                    mem_req_o = 1'b1;
                    iord_o    = 1'b1;
                    we_o      = !timeout;
                end
                S_RTYPE_EX: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = 2'b10;
                end
                S_ALU_WB: begin
                    reg_dst_o = 1'b1;
                    we3_o     = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = 2'b01;
                    pc_src_o    = 2'b01;
                    branch_o    = 1'b1;
                end
                S_ADDI_EX: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                end
                S_ADDI_WB:  we3_o = 1'b1;
                S_JUMP: begin
                    pc_src_o   = 2'b10;
                    pc_write_o = 1'b1;
                end
`ifdef MC_BNE_EN
                S_BNE: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = 2'b01;
                    pc_src_o    = 2'b01;
                    branch_o    = 1'b1;
                    branch_ne_o = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle successor to the single-cycle main decoder.
- Moore FSM sequencing each MIPS instruction over 3–5 states, sharing one ALU and one unified memory port.
- Adds a memory ready handshake with an optional wait-limit watchdog.
- Sits between the instruction register opcode field and the multicycle datapath muxes, enables and ALU decoder; alu_op keeps the existing 2-bit encoding.

Parameters:
- OPCODE_W, 6, opcode width; opcode constants are zero-extended to this width.
- WAIT_LIMIT, 0, max consecutive mem_ready-low cycles in a memory state. 0 = wait forever.
- STATE_W, 4, state register width; must be >= 4.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  OPCODE_W  instr[31:26] from instruction register
- mem_ready  in  1  memory completes access this cycle
- mem_req  out  1  memory access requested
- iord  out  1  0 = address from PC, 1 = from ALUOut
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC write
- branch  out  1  PC write if ALU zero
- alu_src_a  out  1  0 = PC, 1 = regA
- alu_src_b  out  2  00 regB, 01 const 4, 10 signimm, 11 signimm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- reg_dst  out  1  1 = rd, 0 = rt
- mem2reg  out  1  1 = writeback from memory data
- we3  out  1  register file write enable
- we  out  1  memory write enable
- illegal_op  out  1  one-cycle pulse, unknown opcode in DECODE
- bus_err  out  1  one-cycle pulse, watchdog expired
- state  out  STATE_W  current state, for debug

Behaviour:
- Reset: state <= FETCH on the clk edge with reset high. While reset is high, every output except state is forced to 0.
- Outputs are Moore, decoded from state only, except:
  - ir_write and pc_write in FETCH are additionally gated by mem_ready.
  - illegal_op and bus_err are registered pulses.
- All outputs not listed for a state are 0.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=pc_write=mem_ready.
  - Stay while !mem_ready; else -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target). Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTYPE_EX
  - 000100 -> BRANCH
  - 001000 -> ADDI_EX
  - 000010 -> JUMP
  - other -> FETCH, with illegal_op=1 next cycle
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD: mem_req=1, iord=1. Stay while !mem_ready; else -> MEMWB.
- MEMWB: reg_dst=0, mem2reg=1, we3=1 -> FETCH.
- MEMWR: mem_req=1, iord=1, we=1. Stay while !mem_ready; else -> FETCH.
- RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALU_WB.
- ALU_WB: reg_dst=1, mem2reg=0, we3=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1 -> FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB.
- ADDI_WB: reg_dst=0, mem2reg=0, we3=1 -> FETCH.
- JUMP: pc_src=10, pc_write=1 -> FETCH.
- Latencies with mem_ready tied high:
  - lw 5 cycles; sw and R-type 4; addi 4; beq 3; j 3; illegal 2.
- Watchdog (WAIT_LIMIT > 0):
  - Counter clears on entry to FETCH, MEMRD or MEMWR.
  - Counter increments each cycle spent there with mem_ready low.
  - On reaching WAIT_LIMIT: bus_err=1 next cycle, state -> FETCH, no we3/we/pc_write issued in that cycle.
  - In FETCH the timeout re-enters FETCH and the counter clears.
  - mem_ready high on the limit cycle wins; no error.
- Opcode is sampled only in DECODE. Changes in other states are ignored.
- Unused state encodings -> FETCH on the next edge.
- Reset mid-instruction aborts it: no further we/we3/pc_write.

Optional Feature:
- Macro: MC_BNE_EN.
- Defined:
  - Opcode 000101 goes DECODE -> BNE.
  - BNE drives the same outputs as BRANCH plus a 1-bit output port branch_ne=1 (PC write if ALU zero is 0) -> FETCH.
  - branch_ne is 0 in all other states and during reset.
- Undefined:
  - No branch_ne port.
  - 000101 is illegal: illegal_op pulse, return to FETCH.

Test Plan:
- Reset held 3 cycles then released, mem_ready=1, opcode=000000 -> outputs 0 during reset; state sequence FETCH, DECODE, RTYPE_EX, ALU_WB, FETCH; we3=1 and reg_dst=1 only in ALU_WB.
- lw (100011) with mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles, mem_req=iord=1 throughout, MEMWB asserts mem2reg=1 and we3=1 exactly once; total 7 cycles.
- sw, beq, addi, j back-to-back, mem_ready=1 -> cycle counts 4, 3, 4, 3; we=1 only in MEMWR; branch=1 with alu_op=01 in BRANCH; pc_src=10 with pc_write=1 in JUMP.
- Opcode 111111 -> DECODE -> FETCH, illegal_op pulses one cycle, no we/we3. With MC_BNE_EN, 000101 reaches BNE with branch_ne=1; without it, illegal_op pulses.
- WAIT_LIMIT=4, mem_ready stuck low in MEMWR -> bus_err pulses after 4 low cycles, state=FETCH, no extra we; mem_ready rising on cycle 4 gives no bus_err.
- Reset asserted in MEMRD -> next state FETCH, MEMWB never entered, we3 stays 0.
